// File: rtl/i2c_sched_pkg.sv
// Shared definitions for the I2C command scheduler: control-word field layout,
// command width and FSM state encoding.
package i2c_sched_pkg;

  localparam int START_BIT  = 31;
  localparam int PAGE_BIT   = 17;
  localparam int RANDOM_BIT = 16;
  localparam int WORD_MSB   = 15;
  localparam int WORD_LSB   = 8;
  localparam int DEV_MSB    = 7;
  localparam int DEV_LSB    = 0;

  localparam int CMD_W  = 18;
  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    WAIT_DONE,
    CORE_RST,
    RESP,
    CLEAR
  } state_t;

  // Request command layout is {page, random, word[7:0], dev[7:0]}.
  function automatic logic [DATA_W-1:0] pack_data0(input logic [CMD_W-1:0] cmd);
    logic [DATA_W-1:0] d;
    d                     = '0;
    d[PAGE_BIT]           = cmd[17];
    d[RANDOM_BIT]         = cmd[16];
    d[WORD_MSB:WORD_LSB]  = cmd[15:8];
    d[DEV_MSB:DEV_LSB]    = cmd[7:0];
    return d;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational grant of the first request at or after
// the pointer, pointer advanced past the winner when the grant is taken.
module rr_arbiter #(
  parameter  int NUM_REQ = 2,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic               any_req,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W-1:0] ptr;
  int               cand;

  // NOTE: every combinationally assigned signal gets a default up front so no
  // path through the block leaves it unassigned and a latch is inferred.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!any_req && req[IDX_W'(cand)]) begin
        any_req   = 1'b1;
        grant_idx = IDX_W'(cand);
      end
    end
  end

  assign grant = any_req ? (NUM_REQ'(1) << grant_idx) : '0;

  // NOTE: state registers use non-blocking assignments; reset is synchronous.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && any_req) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_cmd_scheduler.sv
// Front-end for the I2C master core: arbitrates requesters, programs the
// control words, sequences start/done, and resets the core on a watchdog timeout.
module i2c_cmd_scheduler
  import i2c_sched_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int TIMEOUT_CYC = 10000,
  parameter int RST_CYC     = 16,
  parameter int GAP_CYC     = 50
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*CMD_W-1:0] req_cmd,
  input  logic [NUM_REQ*32-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_err,
  output logic [31:0]              i2c_data0,
  output logic [31:0]              i2c_data1,
  input  logic [31:0]              i2c_data2,
  input  logic                     i2c_busy,
  input  logic                     i2c_done,
  output logic                     i2c_rst_n,
  output logic                     sched_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RST_W = $clog2(RST_CYC + 1);
  localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;

  state_t             state, state_nx;
  logic [31:0]        data0_nx, data1_nx, rdata_nx;
  logic               err_nx, core_rst_n_nx;
  logic [TMO_W-1:0]   tmo_cnt, tmo_nx;
  logic [RST_W-1:0]   rst_cnt, rst_nx;
  logic [GAP_W-1:0]   gap_cnt, gap_nx;
  logic [IDX_W-1:0]   owner, owner_nx;
  logic               any_req, take;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (take),
    .any_req   (any_req),
    .grant_idx (grant_idx),
    .grant     (grant)
  );

  assign take       = !rst && (state == IDLE) && (gap_cnt == '0) && any_req;
  assign req_ready  = take ? grant : '0;
  assign rsp_valid  = (!rst && state == RESP) ? (NUM_REQ'(1) << owner) : '0;
  assign sched_busy = (state != IDLE) || (gap_cnt != '0);

  always_comb begin
    state_nx = state;
    data0_nx = i2c_data0;
    data1_nx = i2c_data1;
    rdata_nx = rsp_rdata;
    err_nx   = rsp_err;
    tmo_nx   = tmo_cnt;
    rst_nx   = rst_cnt;
    gap_nx   = gap_cnt;
    owner_nx = owner;
    unique case (state)
      IDLE: begin
        if (gap_cnt != '0) begin
          gap_nx = gap_cnt - 1'b1;
        end else if (any_req) begin
          owner_nx = grant_idx;
          data0_nx = pack_data0(req_cmd[CMD_W*int'(grant_idx) +: CMD_W]);
          data1_nx = req_wdata[32*int'(grant_idx) +: 32];
          state_nx = LOAD;
        end
      end
      LOAD: begin
        data0_nx[START_BIT] = 1'b1;
        tmo_nx              = '0;
        state_nx            = START;
      end
      START, WAIT_DONE: begin
        // A done seen on the final watchdog cycle still counts as success.
        if (i2c_done) begin
          if (state == WAIT_DONE) begin
            rdata_nx            = i2c_data0[DEV_LSB] ? i2c_data2 : '0;
            err_nx              = 1'b0;
            data0_nx[START_BIT] = 1'b0;
            state_nx            = RESP;
          end else begin
            state_nx = WAIT_DONE;
          end
        end else if (tmo_cnt >= TMO_W'(TIMEOUT_CYC - 1)) begin
          data0_nx = '0;
          rst_nx   = '0;
          state_nx = CORE_RST;
        end else begin
          tmo_nx = tmo_cnt + 1'b1;
          if (i2c_busy) state_nx = WAIT_DONE;
        end
      end
      CORE_RST: begin
        if (rst_cnt == RST_W'(RST_CYC - 1)) begin
          rdata_nx = '0;
          err_nx   = 1'b1;
          state_nx = RESP;
        end else begin
          rst_nx = rst_cnt + 1'b1;
        end
      end
      RESP: begin
        data0_nx = '0;
        state_nx = CLEAR;
      end
      CLEAR: begin
        data0_nx = '0;
        if (!i2c_done && !i2c_busy) begin
          gap_nx   = GAP_W'(GAP_CYC);
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    core_rst_n_nx = (state_nx != CORE_RST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      i2c_data0 <= '0;
      i2c_data1 <= '0;
      i2c_rst_n <= 1'b1;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      tmo_cnt   <= '0;
      rst_cnt   <= '0;
      gap_cnt   <= '0;
      owner     <= '0;
    end else begin
      state     <= state_nx;
      i2c_data0 <= data0_nx;
      i2c_data1 <= data1_nx;
      i2c_rst_n <= core_rst_n_nx;
      rsp_rdata <= rdata_nx;
      rsp_err   <= err_nx;
      tmo_cnt   <= tmo_nx;
      rst_cnt   <= rst_nx;
      gap_cnt   <= gap_nx;
      owner     <= owner_nx;
    end
  end

endmodule
